// File: rtl/mips_mc_control_pkg.sv
// Shared constants for the multi-cycle MIPS controller: state codes, opcode/funct
// values, ALU operation codes and the bundled control-word type.
package mips_mc_control_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational funct-field decoder for R-type instructions; valid flags the
// five supported operations.
module mips_alu_decoder
  import mips_mc_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_ctrl = ALU_AND;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: one state register, control word decoded from the
// current state plus the handshake/flag inputs that qualify individual strobes.
module mips_mc_control
  import mips_mc_control_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  logic [3:0] state;
  logic [3:0] state_next;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;
  logic [2:0] funct_alu;
  logic       funct_ok;

  mips_alu_decoder u_alu_decoder (
    .funct    (i_funct),
    .alu_ctrl (funct_alu),
    .valid    (funct_ok)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    ctrl       = CTRL_IDLE;
    state_next = S_FETCH;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.ir_write  = i_mem_ready;
        ctrl.pc_write  = i_mem_ready;
        state_next     = i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_ctrl  = ALU_ADD;
        case (i_opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      ctrl.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_ctrl  = ALU_ADD;
        state_next     = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        state_next   = i_mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        state_next     = i_mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_ctrl  = funct_alu;
        ctrl.illegal   = !funct_ok;
        state_next     = funct_ok ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_ctrl  = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_write  = i_zero;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_ctrl  = ALU_ADD;
        state_next     = S_ADDIWB;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

  // While reset is held the state already reads FETCH, so the word is forced idle
  // to keep FETCH's memory request and ready-qualified loads off the bus.
  assign ctrl_out = i_rst_n ? ctrl : CTRL_IDLE;

  assign o_mem_req    = ctrl_out.mem_req;
  assign o_mem_write  = ctrl_out.mem_write;
  assign o_iord       = ctrl_out.iord;
  assign o_ir_write   = ctrl_out.ir_write;
  assign o_pc_write   = ctrl_out.pc_write;
  assign o_pc_src     = ctrl_out.pc_src;
  assign o_reg_write  = ctrl_out.reg_write;
  assign o_reg_dst    = ctrl_out.reg_dst;
  assign o_mem_to_reg = ctrl_out.mem_to_reg;
  assign o_alu_src_a  = ctrl_out.alu_src_a;
  assign o_alu_src_b  = ctrl_out.alu_src_b;
  assign o_alu_ctrl   = ctrl_out.alu_ctrl;
  assign o_illegal    = ctrl_out.illegal;
  assign o_state      = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: directed vector table, reset-abort sequences and
// random instruction streams checked against a per-instruction reference model.
`timescale 1ns/1ps
module tb_mips_mc_control;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_write;
  logic [1:0] o_pc_src;
  logic       o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [2:0] o_alu_ctrl;
  logic       o_illegal;
  logic [3:0] o_state;

  mips_mc_control dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_opcode     (i_opcode),
    .i_funct      (i_funct),
    .i_zero       (i_zero),
    .i_mem_ready  (i_mem_ready),
    .o_mem_req    (o_mem_req),
    .o_mem_write  (o_mem_write),
    .o_iord       (o_iord),
    .o_ir_write   (o_ir_write),
    .o_pc_write   (o_pc_write),
    .o_pc_src     (o_pc_src),
    .o_reg_write  (o_reg_write),
    .o_reg_dst    (o_reg_dst),
    .o_mem_to_reg (o_mem_to_reg),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_ctrl   (o_alu_ctrl),
    .o_illegal    (o_illegal),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle of observable controller behaviour.
  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic       illegal;
  } obs_t;

  typedef struct {
    obs_t o;
    logic ready;
    logic zero;
  } cyc_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [7:0]  stall;
    int          len;
    logic [31:0] seq;
    logic [7:0]  rw, pw, mw, il;
    int          alu_cyc;
    logic [2:0]  alu;
  } vec_t;

  cyc_t plan[$];
  vec_t vecs[13];

  function automatic obs_t sample();
    obs_t o;
    o.st = o_state;         o.mem_req = o_mem_req;     o.mem_write = o_mem_write;
    o.iord = o_iord;        o.ir_write = o_ir_write;   o.pc_write = o_pc_write;
    o.pc_src = o_pc_src;    o.reg_write = o_reg_write; o.reg_dst = o_reg_dst;
    o.mem_to_reg = o_mem_to_reg; o.src_a = o_alu_src_a; o.src_b = o_alu_src_b;
    o.alu = o_alu_ctrl;     o.illegal = o_illegal;
    return o;
  endfunction

  function automatic logic [5:0] strobes();
    return {o_mem_req, o_mem_write, o_ir_write, o_pc_write, o_reg_write, o_illegal};
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input obs_t o, input logic ready, input logic zero);
    cyc_t c;
    c.o = o; c.ready = ready; c.zero = zero;
    plan.push_back(c);
  endtask

  // Reference model: expands one instruction into its expected cycle-by-cycle trace.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, input int mwait);
    obs_t o;
    logic z;
    logic legal_fn;
    logic [2:0] fn_alu;
    for (int w = 0; w <= fwait; w++) begin
      o = blank(4'd0); o.mem_req = 1'b1; o.src_b = 2'b01; o.alu = 3'b010;
      o.ir_write = (w == fwait); o.pc_write = (w == fwait);
      push(o, w == fwait, rbit());
    end
    o = blank(4'd1); o.src_b = 2'b11; o.alu = 3'b010;
    o.illegal = !(op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02});
    push(o, rbit(), rbit());
    case (op)
      6'h23, 6'h2b: begin
        o = blank(4'd2); o.src_a = 1'b1; o.src_b = 2'b10; o.alu = 3'b010;
        push(o, rbit(), rbit());
        for (int w = 0; w <= mwait; w++) begin
          o = blank(op == 6'h23 ? 4'd3 : 4'd5);
          o.mem_req = 1'b1; o.iord = 1'b1; o.mem_write = (op == 6'h2b);
          push(o, w == mwait, rbit());
        end
        if (op == 6'h23) begin
          o = blank(4'd4); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          push(o, rbit(), rbit());
        end
      end
      6'h00: begin
        legal_fn = 1'b1;
        case (fn)
          6'h20:   fn_alu = 3'b010;
          6'h22:   fn_alu = 3'b110;
          6'h24:   fn_alu = 3'b000;
          6'h25:   fn_alu = 3'b001;
          6'h2a:   fn_alu = 3'b111;
          default: begin fn_alu = 3'b000; legal_fn = 1'b0; end
        endcase
        o = blank(4'd6); o.src_a = 1'b1; o.alu = fn_alu; o.illegal = !legal_fn;
        push(o, rbit(), rbit());
        if (legal_fn) begin
          o = blank(4'd7); o.reg_write = 1'b1; o.reg_dst = 1'b1;
          push(o, rbit(), rbit());
        end
      end
      6'h04: begin
        z = rbit();
        o = blank(4'd8); o.src_a = 1'b1; o.alu = 3'b110; o.pc_src = 2'b01; o.pc_write = z;
        push(o, rbit(), z);
      end
      6'h08: begin
        o = blank(4'd9); o.src_a = 1'b1; o.src_b = 2'b10; o.alu = 3'b010;
        push(o, rbit(), rbit());
        o = blank(4'd10); o.reg_write = 1'b1;
        push(o, rbit(), rbit());
      end
      6'h02: begin
        o = blank(4'd11); o.pc_write = 1'b1; o.pc_src = 2'b10;
        push(o, rbit(), rbit());
      end
      default: ;
    endcase
  endtask

  // Entered just after a falling edge; leaves just after the falling edge that
  // begins the cycle following the instruction.
  task automatic drain_plan(input int idx);
    cyc_t c;
    int   k = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      i_mem_ready = c.ready;
      i_zero      = c.zero;
      #1;
      check($sformatf("rand i%0d op%0h fn%0h c%0d", idx, i_opcode, i_funct, k),
            32'(sample()), 32'(c.o));
      k++;
      @(negedge i_clk);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] got_seq = '0;
    logic [7:0]  rw = '0, pw = '0, mw = '0, il = '0;
    i_opcode = v.op; i_funct = v.fn; i_zero = v.zero;
    for (int c = 0; c < v.len; c++) begin
      i_mem_ready = !v.stall[c];
      #1;
      got_seq[c*4 +: 4] = o_state;
      rw[c] = o_reg_write; pw[c] = o_pc_write; mw[c] = o_mem_write; il[c] = o_illegal;
      if (c == v.alu_cyc) check({v.name, " alu_ctrl"}, 32'(o_alu_ctrl), 32'(v.alu));
      @(negedge i_clk);
    end
    i_mem_ready = 1'b0;
    #1;
    check({v.name, " states"},    got_seq, v.seq);
    check({v.name, " reg_write"}, 32'(rw), 32'(v.rw));
    check({v.name, " pc_write"},  32'(pw), 32'(v.pw));
    check({v.name, " mem_write"}, 32'(mw), 32'(v.mw));
    check({v.name, " illegal"},   32'(il), 32'(v.il));
    check({v.name, " back to fetch"}, 32'(o_state), 32'd0);
  endtask

  // Walks an instruction forward n cycles with ready high, then asserts reset.
  task automatic reset_after(input string name, input logic [5:0] op, input int n,
                             input logic [3:0] exp_st);
    i_opcode = op; i_funct = 6'h20; i_mem_ready = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (c == n - 1) i_mem_ready = 1'b0;
      @(negedge i_clk);
    end
    #1;
    check({name, " pre-reset state"}, 32'(o_state), 32'(exp_st));
    i_mem_ready = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check({name, " async state"},   32'(o_state), 32'd0);
    check({name, " async strobes"}, 32'(strobes()), 32'd0);
    @(posedge i_clk); #1;
    check({name, " held strobes"},  32'(strobes()), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check({name, " restart fetch"}, 32'({o_state, o_mem_req, o_reg_write, o_mem_write}),
          32'({4'd0, 1'b1, 1'b0, 1'b0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op_pool[8] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h00};
    logic [5:0] fn_pool[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [5:0] op, fn;

    vecs[0]  = '{"add",     6'h00, 6'h20, 1'b0, 8'h00, 4, 32'h7610,    8'h08, 8'h01, 8'h00, 8'h00, 2, 3'b010};
    vecs[1]  = '{"sub",     6'h00, 6'h22, 1'b0, 8'h00, 4, 32'h7610,    8'h08, 8'h01, 8'h00, 8'h00, 2, 3'b110};
    vecs[2]  = '{"slt",     6'h00, 6'h2a, 1'b0, 8'h00, 4, 32'h7610,    8'h08, 8'h01, 8'h00, 8'h00, 2, 3'b111};
    vecs[3]  = '{"lw wait2",6'h23, 6'h00, 1'b0, 8'h18, 7, 32'h4333210, 8'h40, 8'h01, 8'h00, 8'h00, 2, 3'b010};
    vecs[4]  = '{"sw",      6'h2b, 6'h00, 1'b0, 8'h00, 4, 32'h5210,    8'h00, 8'h01, 8'h08, 8'h00, 2, 3'b010};
    vecs[5]  = '{"beq z1",  6'h04, 6'h00, 1'b1, 8'h00, 3, 32'h810,     8'h00, 8'h05, 8'h00, 8'h00, 2, 3'b110};
    vecs[6]  = '{"beq z0",  6'h04, 6'h00, 1'b0, 8'h00, 3, 32'h810,     8'h00, 8'h01, 8'h00, 8'h00, 2, 3'b110};
    vecs[7]  = '{"j",       6'h02, 6'h00, 1'b0, 8'h00, 3, 32'hB10,     8'h00, 8'h05, 8'h00, 8'h00, 1, 3'b010};
    vecs[8]  = '{"addi",    6'h08, 6'h00, 1'b0, 8'h00, 4, 32'hA910,    8'h08, 8'h01, 8'h00, 8'h00, 2, 3'b010};
    vecs[9]  = '{"bad op",  6'h3f, 6'h00, 1'b0, 8'h00, 2, 32'h10,      8'h00, 8'h01, 8'h00, 8'h02, 1, 3'b010};
    vecs[10] = '{"bad fn",  6'h00, 6'h01, 1'b0, 8'h00, 3, 32'h610,     8'h00, 8'h01, 8'h00, 8'h04, 0, 3'b010};
    vecs[11] = '{"fetch w2",6'h00, 6'h20, 1'b0, 8'h03, 6, 32'h761000,  8'h20, 8'h04, 8'h00, 8'h00, 4, 3'b010};
    vecs[12] = '{"sw wait1",6'h2b, 6'h00, 1'b0, 8'h08, 5, 32'h55210,   8'h00, 8'h01, 8'h18, 8'h00, 0, 3'b010};

    i_rst_n = 1'b0; i_opcode = '0; i_funct = '0; i_zero = 1'b0; i_mem_ready = 1'b1;
    #12;
    check("reset state",   32'(o_state), 32'd0);
    check("reset strobes", 32'(strobes()), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    reset_after("rst in exec",  6'h00, 2, 4'd6);
    run_vec(vecs[0]);
    reset_after("rst in memwr", 6'h2b, 3, 4'd5);
    run_vec(vecs[4]);

    for (int i = 0; i < 200; i++) begin
      op = op_pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      fn = fn_pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
      i_opcode = op; i_funct = fn;
      model_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
      drain_plan(i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_clk  in  1  rising-edge clock; i_rst_n  in  1  async active-low reset.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_opcode  in  6  instr[31:26]
- i_funct  in  6  instr[5:0]
- i_zero  in  1  ALU zero flag
- i_mem_ready  in  1  memory completes access this cycle
- o_mem_req  out  1  memory access request
- o_mem_write  out  1  store strobe
- o_iord  out  1  address source: 0=PC, 1=ALUOut
- o_ir_write  out  1  instruction register load
- o_pc_write  out  1  PC load, unconditional or branch-qualified
- o_pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target
- o_reg_write  out  1  drives register-file i_we
- o_reg_dst  out  1  waddr: 0=rt, 1=rd
- o_mem_to_reg  out  1  wdata: 0=ALUOut, 1=MDR
- o_alu_src_a  out  1  0=PC, 1=A
- o_alu_src_b  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- o_alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- o_illegal  out  1  one-cycle pulse on unsupported opcode/funct
- o_state  out  4  current state, for debug

Function
REQ-003 The block SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH next cycle with all strobes 0.
REQ-004 FETCH SHALL assert o_mem_req, iord=0, src_a=0, src_b=01, alu_ctrl=add and pc_src=00; ir_write and pc_write SHALL assert only in cycles where i_mem_ready=1; the FSM SHALL hold FETCH while i_mem_ready=0.
REQ-005 DECODE SHALL drive src_a=0, src_b=11, alu_ctrl=add, then transition: LW/SW (100011/101011)->MEMADR; R-type (000000)->EXEC; BEQ (000100)->BRANCH; ADDI (001000)->ADDIEX; J (000010)->JUMP; any other opcode->FETCH with o_illegal=1.
REQ-006 MEMADR SHALL drive src_a=1, src_b=10, alu_ctrl=add, then go to MEMRD for LW or MEMWR for SW.
REQ-007 MEMRD SHALL assert mem_req with iord=1 and hold until i_mem_ready=1, then go to MEMWB; MEMWR SHALL assert mem_req, mem_write and iord=1, hold until i_mem_ready=1, then go to FETCH.
REQ-008 MEMWB SHALL assert reg_write with reg_dst=0 and mem_to_reg=1 for exactly one cycle, then go to FETCH.
REQ-009 EXEC SHALL drive src_a=1, src_b=00 and alu_ctrl decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); an unsupported funct SHALL pulse o_illegal and return to FETCH without entering ALUWB.
REQ-010 ALUWB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-011 BRANCH SHALL drive src_a=1, src_b=00, alu_ctrl=sub and pc_src=01, assert pc_write only if i_zero=1, then go to FETCH.
REQ-012 ADDIEX SHALL drive src_a=1, src_b=10 and alu_ctrl=add; ADDIWB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0; both SHALL then advance (ADDIEX->ADDIWB, ADDIWB->FETCH).
REQ-013 JUMP SHALL assert pc_write with pc_src=10, then go to FETCH.
REQ-014 Any output not specified for a state SHALL be 0; reg_write, pc_write, ir_write and mem_write SHALL never assert outside the states named above.
REQ-015 Latency SHALL be (with zero memory wait): R-type/ADDI 4 cycles, LW 5, SW 4, BEQ/J 3; each wait cycle adds 1.

Reset
REQ-016 While i_rst_n=0, state SHALL be FETCH immediately (asynchronously) and every strobe (mem_req, mem_write, ir_write, pc_write, reg_write, illegal) SHALL be 0; on release the first rising edge SHALL evaluate FETCH.
REQ-017 Reset asserted mid-instruction SHALL abort it with no further write strobes.

Structure
REQ-018 A shared package SHALL hold the state encodings, opcode and funct constants, and alu_ctrl codes.
REQ-019 Funct-to-alu_ctrl decoding SHALL be a combinational sub-module named mips_alu_decoder.

Verification
REQ-020 Reset with i_rst_n=0 mid-EXEC: o_state=0 within the same cycle and all strobes 0.
REQ-021 ADD (opcode 000000, funct 100000) with ready=1: states 0,1,6,7; reg_write=1 only in state 7, reg_dst=1, alu_ctrl=010 in state 6.
REQ-022 LW with i_mem_ready low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4; reg_write with mem_to_reg=1 in state 4.
REQ-023 BEQ with zero=1 gives pc_write=1 and pc_src=01 in state 8; with zero=0, pc_write=0.
REQ-024 Opcode 111111 gives o_illegal=1 for one cycle in DECODE, then FETCH with no write strobe; funct 000001 gives the same behaviour via EXEC.
REQ-025 SW with ready=1: sequence 0,1,2,5; mem_write=1 and iord=1 in state 5; reg_write stays 0 throughout.
